// File: rtl/scratch_mem_arbiter.sv
// rtl/scratch_mem_arbiter.sv - ownership arbiter for the shared dual-read/single-write scratch memory
// Optional round-robin arbitration: define SCRATCH_ARB_RR_EN (default build is fixed priority, lowest index wins).
module scratch_mem_arbiter #(
  parameter int NUM_CLIENTS = 3,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int RD_LAT      = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_CLIENTS-1:0]        req,
  output logic [NUM_CLIENTS-1:0]        grant,
  input  logic [NUM_CLIENTS-1:0]        re,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] raddr0,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] raddr1,
  input  logic [NUM_CLIENTS-1:0]        we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] waddr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] wdata,
  output logic [DATA_W-1:0]             rdata0,
  output logic [DATA_W-1:0]             rdata1,
  output logic [NUM_CLIENTS-1:0]        rvalid,
  output logic                          mem_re,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_raddr0,
  output logic [ADDR_W-1:0]             mem_raddr1,
  output logic [ADDR_W-1:0]             mem_waddr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata0,
  input  logic [DATA_W-1:0]             mem_rdata1,
  output logic                          conflict_err
);

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWNED = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [2:0] DRAIN_LAST = 3'(RD_LAT - 1);

  logic [1:0]             state_q, state_d;
  logic [NUM_CLIENTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [2:0]             drain_cnt_q, drain_cnt_d;
  logic                   conflict_q, conflict_d;
  logic [RD_LAT-1:0]      pipe_vld_q;
  logic [IDX_W-1:0]       pipe_idx_q [RD_LAT];
  logic [IDX_W-1:0]       winner;
  logic                   owned;

`ifdef SCRATCH_ARB_RR_EN
  logic [IDX_W-1:0] last_q;
  logic [IDX_W:0]   cand;

  // Descending scan so the candidate closest to last_q+1 is assigned last and wins.
  always_comb begin
    winner = '0;
    cand   = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      cand = {1'b0, last_q} + (IDX_W+1)'(k + 1);
      if (cand >= (IDX_W+1)'(NUM_CLIENTS)) cand = cand - (IDX_W+1)'(NUM_CLIENTS);
      if (req[cand[IDX_W-1:0]]) winner = cand[IDX_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= IDX_W'(NUM_CLIENTS - 1);
    end else if (state_q == S_IDLE && |req) begin
      last_q <= winner;
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      if (req[k]) winner = IDX_W'(k);
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          owner_d         = winner;
          state_d         = S_OWNED;
        end
      end
      S_OWNED: begin
        if (!req[owner_q]) begin
          grant_d     = '0;
          drain_cnt_d = '0;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) state_d = S_IDLE;
        else drain_cnt_d = drain_cnt_q + 3'd1;
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign owned      = (state_q == S_OWNED);
  // Non-owners never reach the memory, so their accesses only raise the sticky flag.
  assign conflict_d = conflict_q | (|((re | we) & ~grant_q));

  always_comb begin
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_raddr0 = '0;
    mem_raddr1 = '0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    if (owned) begin
      mem_re     = re[owner_q];
      mem_we     = we[owner_q];
      mem_raddr0 = raddr0[owner_q*ADDR_W +: ADDR_W];
      mem_raddr1 = raddr1[owner_q*ADDR_W +: ADDR_W];
      mem_waddr  = waddr[owner_q*ADDR_W +: ADDR_W];
      mem_wdata  = wdata[owner_q*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      drain_cnt_q <= '0;
      conflict_q  <= 1'b0;
      pipe_vld_q  <= '0;
      for (int s = 0; s < RD_LAT; s++) pipe_idx_q[s] <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      drain_cnt_q   <= drain_cnt_d;
      conflict_q    <= conflict_d;
      pipe_vld_q[0] <= mem_re;
      pipe_idx_q[0] <= owner_q;
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_vld_q[s] <= pipe_vld_q[s-1];
        pipe_idx_q[s] <= pipe_idx_q[s-1];
      end
    end
  end

  always_comb begin
    rvalid = '0;
    if (pipe_vld_q[RD_LAT-1]) rvalid[pipe_idx_q[RD_LAT-1]] = 1'b1;
  end

  assign grant        = grant_q;
  assign conflict_err = conflict_q;
  assign rdata0       = mem_rdata0;
  assign rdata1       = mem_rdata1;

endmodule

// File: tb/tb_scratch_mem_arbiter.sv
// tb/tb_scratch_mem_arbiter.sv - directed self-checking bench for scratch_mem_arbiter
module tb_scratch_mem_arbiter;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  // a: 3 clients, RD_LAT=1
  logic [2:0]  a_req, a_grant, a_re, a_we, a_rvalid;
  logic [23:0] a_raddr0, a_raddr1, a_waddr;
  logic [95:0] a_wdata;
  logic [31:0] a_rdata0, a_rdata1, a_mem_wdata, a_mem_rdata0, a_mem_rdata1;
  logic        a_mem_re, a_mem_we, a_conflict;
  logic [7:0]  a_mem_raddr0, a_mem_raddr1, a_mem_waddr, a_rq;

  // b: 3 clients, RD_LAT=3
  logic [2:0]  b_req, b_grant, b_re, b_we, b_rvalid;
  logic [23:0] b_raddr0, b_raddr1, b_waddr;
  logic [95:0] b_wdata;
  logic [31:0] b_rdata0, b_rdata1, b_mem_wdata;
  logic        b_mem_re, b_mem_we, b_conflict;
  logic [7:0]  b_mem_raddr0, b_mem_raddr1, b_mem_waddr;

  // c: 4 clients, RD_LAT=2
  logic [3:0]   c_req, c_grant, c_re, c_we, c_rvalid;
  logic [31:0]  c_raddr0, c_raddr1, c_waddr;
  logic [127:0] c_wdata;
  logic [31:0]  c_rdata0, c_rdata1, c_mem_wdata;
  logic         c_mem_re, c_mem_we, c_conflict;
  logic [7:0]   c_mem_raddr0, c_mem_raddr1, c_mem_waddr;

  int exp_o [4];

  scratch_mem_arbiter #(.NUM_CLIENTS(3), .ADDR_W(8), .DATA_W(32), .RD_LAT(1)) u_a (
    .clk(clk), .reset_n(reset_n), .req(a_req), .grant(a_grant), .re(a_re),
    .raddr0(a_raddr0), .raddr1(a_raddr1), .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
    .rdata0(a_rdata0), .rdata1(a_rdata1), .rvalid(a_rvalid), .mem_re(a_mem_re), .mem_we(a_mem_we),
    .mem_raddr0(a_mem_raddr0), .mem_raddr1(a_mem_raddr1), .mem_waddr(a_mem_waddr),
    .mem_wdata(a_mem_wdata), .mem_rdata0(a_mem_rdata0), .mem_rdata1(a_mem_rdata1),
    .conflict_err(a_conflict)
  );

  scratch_mem_arbiter #(.NUM_CLIENTS(3), .ADDR_W(8), .DATA_W(32), .RD_LAT(3)) u_b (
    .clk(clk), .reset_n(reset_n), .req(b_req), .grant(b_grant), .re(b_re),
    .raddr0(b_raddr0), .raddr1(b_raddr1), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .rdata0(b_rdata0), .rdata1(b_rdata1), .rvalid(b_rvalid), .mem_re(b_mem_re), .mem_we(b_mem_we),
    .mem_raddr0(b_mem_raddr0), .mem_raddr1(b_mem_raddr1), .mem_waddr(b_mem_waddr),
    .mem_wdata(b_mem_wdata), .mem_rdata0(32'h0), .mem_rdata1(32'h0),
    .conflict_err(b_conflict)
  );

  scratch_mem_arbiter #(.NUM_CLIENTS(4), .ADDR_W(8), .DATA_W(32), .RD_LAT(2)) u_c (
    .clk(clk), .reset_n(reset_n), .req(c_req), .grant(c_grant), .re(c_re),
    .raddr0(c_raddr0), .raddr1(c_raddr1), .we(c_we), .waddr(c_waddr), .wdata(c_wdata),
    .rdata0(c_rdata0), .rdata1(c_rdata1), .rvalid(c_rvalid), .mem_re(c_mem_re), .mem_we(c_mem_we),
    .mem_raddr0(c_mem_raddr0), .mem_raddr1(c_mem_raddr1), .mem_waddr(c_mem_waddr),
    .mem_wdata(c_mem_wdata), .mem_rdata0(32'h0), .mem_rdata1(32'h0),
    .conflict_err(c_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle memory for instance a: data encodes the address read.
  always @(posedge clk) a_rq <= a_mem_raddr0;
  assign a_mem_rdata0 = {24'hC0DE00, a_rq};
  assign a_mem_rdata1 = 32'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
`ifdef SCRATCH_ARB_RR_EN
    exp_o = '{0, 1, 2, 0};
`else
    exp_o = '{0, 0, 0, 0};
`endif
    reset_n = 1'b0;
    a_req = '0; a_re = '0; a_we = '0; a_raddr0 = '0; a_raddr1 = '0; a_waddr = '0; a_wdata = '0;
    b_req = '0; b_re = '0; b_we = '0; b_raddr0 = '0; b_raddr1 = '0; b_waddr = '0; b_wdata = '0;
    c_req = '0; c_re = '0; c_we = '0; c_raddr0 = '0; c_raddr1 = '0; c_waddr = '0; c_wdata = '0;

    tick(); tick(); #1;
    check("rst_a_grant", a_grant, 0);
    check("rst_a_rvalid", a_rvalid, 0);
    check("rst_a_conflict", a_conflict, 0);
    check("rst_a_mem_re", a_mem_re, 0);
    check("rst_a_mem_we", a_mem_we, 0);
    check("rst_c_grant", c_grant, 0);
    check("rst_c_mem_waddr", c_mem_waddr, 0);
    tick(); reset_n = 1'b1;

    // Basic phase on a
    tick(); a_req = 3'b001; #1;
    check("a_grant_pre", a_grant, 3'b000);
    tick(); #1;
    check("a_grant_lat", a_grant, 3'b001);
    tick(); a_re = 3'b001; a_raddr0[7:0] = 8'h05; a_raddr1[7:0] = 8'h07; #1;
    check("a_mem_re", a_mem_re, 1);
    check("a_mem_raddr0", a_mem_raddr0, 8'h05);
    check("a_mem_raddr1", a_mem_raddr1, 8'h07);
    tick(); a_re = 3'b000; #1;
    check("a_rvalid", a_rvalid, 3'b001);
    check("a_rdata0", a_rdata0, 32'hC0DE0005);
    tick(); #1;
    check("a_rvalid_off", a_rvalid, 3'b000);

    // Arbitration order from a fresh reset
    a_req = 3'b000;
    reset_n = 1'b0;
    tick(); tick(); reset_n = 1'b1;
    tick(); a_req = 3'b111;
    tick(); #1;
    check("a_arb0", a_grant, 3'(1 << exp_o[0]));
    for (int k = 1; k < 4; k++) begin
      tick(); a_req = 3'b111 & ~3'(1 << exp_o[k-1]);
      tick(); a_req = 3'b111; #1;
      check($sformatf("a_drain%0d", k), a_grant, 3'b000);
      tick();
      tick(); #1;
      check($sformatf("a_arb%0d", k), a_grant, 3'(1 << exp_o[k]));
    end

    // Conflict: client 2 writes while client 0 owns
    tick(); a_we = 3'b100; a_waddr[23:16] = 8'h10; a_wdata[95:64] = 32'hDEAD; #1;
    check("a_conf_mem_we", a_mem_we, 0);
    check("a_conf_mem_waddr", a_mem_waddr, 0);
    check("a_conf_pre", a_conflict, 0);
    tick(); a_we = 3'b000; a_req = 3'b000; #1;
    check("a_conf_set", a_conflict, 1);
    repeat (20) tick();
    #1;
    check("a_conf_sticky", a_conflict, 1);
    check("a_idle_grant", a_grant, 0);

    // Handover with drain on b (RD_LAT=3)
    tick(); b_req = 3'b110;
    tick(); #1;
    check("b_grant1", b_grant, 3'b010);
    tick(); b_re = 3'b010; b_req = 3'b100; #1;
    check("b_last_re", b_mem_re, 1);
    tick(); b_re = 3'b000; #1;
    check("b_drain_g1", b_grant, 3'b000);
    tick(); #1;
    check("b_drain_g2", b_grant, 3'b000);
    check("b_rvalid_early", b_rvalid, 3'b000);
    tick(); #1;
    check("b_drain_g3", b_grant, 3'b000);
    check("b_rvalid", b_rvalid, 3'b010);
    tick(); #1;
    check("b_idle_g", b_grant, 3'b000);
    check("b_rvalid_off", b_rvalid, 3'b000);
    tick(); #1;
    check("b_grant2", b_grant, 3'b100);
    b_req = 3'b000;

    // Write path on c (4 clients)
    tick(); c_req = 4'b1000;
    tick(); #1;
    check("c_grant3", c_grant, 4'b1000);
    tick(); c_we = 4'b1000; c_waddr[31:24] = 8'hFF; c_wdata[127:96] = 32'h1234; #1;
    check("c_mem_we", c_mem_we, 1);
    check("c_mem_waddr", c_mem_waddr, 8'hFF);
    check("c_mem_wdata", c_mem_wdata, 32'h1234);
    tick(); c_we = 4'b0000; c_req = 4'b0001;
    tick(); tick(); tick();
    tick(); c_re = 4'b0001; #1;
    check("c_grant0", c_grant, 4'b0001);
    tick();
    tick(); c_re = 4'b0000; #1;
    check("c_rvalid_pre_rst", c_rvalid, 4'b0001);

    // Asynchronous reset with a second read still in flight
    reset_n = 1'b0; c_req = 4'b0000; #1;
    check("c_rst_grant", c_grant, 0);
    check("c_rst_rvalid", c_rvalid, 0);
    tick(); tick(); reset_n = 1'b1;
    tick(); tick(); #1;
    check("c_post_grant", c_grant, 0);
    check("c_post_rvalid", c_rvalid, 0);
    c_req = 4'b0010;
    tick(); #1;
    check("c_regrant", c_grant, 4'b0010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scratch_mem_arbiter.md
# scratch_mem_arbiter

Parametrised arbiter for the shared dual-read/single-write scratch memory used by the histogram-equalisation pipeline stages: histogram, CDF and divider, plus future stages. Each client requests exclusive ownership. The block grants one owner at a time, routes only the owner's accesses to the memory, and returns read data with a per-client valid aligned to memory read latency. Before handing ownership to another client it drains in-flight reads, and it flags illegal accesses from non-owners.

## Interface
Parameters:
- NUM_CLIENTS, 3, number of requesting stages (2..8); index 0 = histogram, 1 = CDF, 2 = divider
- ADDR_W, 8, scratch memory address width
- DATA_W, 32, scratch memory data width
- RD_LAT, 1, memory read latency in cycles (1..4)

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset_n  in  1  asynchronous active-low reset
- req  in  NUM_CLIENTS  ownership request per client, held for whole phase
- grant  out  NUM_CLIENTS  registered one-hot (or zero) ownership
- re  in  NUM_CLIENTS  read enable per client (both ports)
- raddr0, raddr1  in  NUM_CLIENTS*ADDR_W  per-client read addresses, client i at [i*ADDR_W +: ADDR_W]
- we  in  NUM_CLIENTS  write enable per client
- waddr  in  NUM_CLIENTS*ADDR_W  per-client write address
- wdata  in  NUM_CLIENTS*DATA_W  per-client write data
- rdata0, rdata1  out  DATA_W  read data broadcast to all clients
- rvalid  out  NUM_CLIENTS  rdata valid for client i
- mem_re, mem_we  out  1  memory read/write enables
- mem_raddr0, mem_raddr1, mem_waddr  out  ADDR_W  memory addresses
- mem_wdata  out  DATA_W  memory write data
- mem_rdata0, mem_rdata1  in  DATA_W  memory read data, RD_LAT cycles after mem_re
- conflict_err  out  1  sticky: a non-owner asserted re or we

## Operation
- FSM states are IDLE, OWNED and DRAIN. Reset state is IDLE.
- IDLE: if any req is high, select a winner (see Configuration), set grant[winner], go to OWNED. If no req is high, stay.
- OWNED: the memory ports mirror the owner: mem_re=re[o], mem_we=we[o], and the addresses and data come from slice o. When req[o]=0, clear grant and go to DRAIN. In this cycle the owner's re/we are still passed through, because the owner-select register is still valid.
- DRAIN: wait RD_LAT cycles with a counter, then go to IDLE. Grant is 0 and all mem_* outputs are 0.
- IDLE and DRAIN: mem_re=0, mem_we=0, all mem addresses and data are 0.
- Read return: an RD_LAT-deep shift register carries (mem_re, owner index).
  - At the tail, rvalid[idx] = 1.
  - rdata0/rdata1 = mem_rdata0/1 passed through combinationally.
- conflict_err: set when any client j with grant[j]=0 asserts re[j] or we[j]. It clears only on reset. The offending access is dropped and never reaches the memory.
- A client that deasserts and reasserts req still goes through DRAIN and re-arbitration.

## Timing
- Reset values: grant=0, rvalid=0, conflict_err=0, state IDLE, drain counter 0, read pipeline cleared. All mem_* outputs are 0.
- Grant latency: req rising in cycle t gives grant in cycle t+1. The client may issue re/we from t+1.
- Read latency: re in cycle t gives rvalid in cycle t+RD_LAT, with mem_rdata valid in the same cycle.
- Handover: the owner drops req in cycle t, so grant drops at t+1. The state is DRAIN for cycles t+1..t+RD_LAT and IDLE at t+RD_LAT+1. The next grant is earliest at t+RD_LAT+2.
- Reads issued in the final OWNED cycle still return their rvalid during DRAIN.
- Simultaneous requests are resolved in a single IDLE cycle. Losers keep req high and wait.
- Asynchronous reset mid-phase or mid-drain clears everything immediately. In-flight reads never produce rvalid.

## Configuration
- SCRATCH_ARB_RR_EN defined: round-robin arbitration. Search starts at index (last_owner+1) mod NUM_CLIENTS. last_owner resets to NUM_CLIENTS-1, so the first search starts at 0.
- SCRATCH_ARB_RR_EN undefined: fixed priority, lowest index wins. The last_owner register is not built.

## Test plan
- Basic phase, RD_LAT=1: req[0]=1 at cycle 2 → grant=001 at cycle 3. Client 0 reads addr 0x05 at cycle 4 → mem_raddr0=0x05 at cycle 4, rvalid=001 at cycle 5 with rdata0 = memory content.
- Handover with drain, RD_LAT=3: client 1 issues a read in its last cycle, then drops req at cycle 10 while req[2] is held high. Required: rvalid[1] at cycle 13, grant=000 for cycles 11..13, grant=100 at cycle 15.
- Arbitration: req=111 with all stages cycled. Without the macro the grant order is 0,0,0… whenever all requests stay high. With SCRATCH_ARB_RR_EN the order is 0,1,2,0.
- Conflict: client 2 asserts we (waddr 0x10, wdata 0xDEAD) while client 0 owns. Required: mem_we=0 and conflict_err=1 from the next cycle, still 1 after 20 idle cycles.
- Reset mid-operation: assert reset_n=0 while client 0 owns with 2 reads in flight (RD_LAT=2). Required: grant=0 and rvalid=0 immediately, and both stay 0 after release until a new req.
- Write path, NUM_CLIENTS=4: owner 3 writes 0x1234 to addr 0xFF → mem_we=1, mem_waddr=0xFF, mem_wdata=0x1234 in the same cycle.
